// File: rtl/uart_arbiter_pkg.sv
// Shared types and constants for the two-requester UART arbiter.
package uart_arbiter_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_REQ   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    localparam logic LOADER = 1'b0;
    localparam logic CORE   = 1'b1;

    localparam int TIMEOUT_CNT_W = 8;

    // Wait counter only has to reach WAIT_LIMIT-1; keep at least one bit.
    function automatic int wait_cnt_w(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/uart_arb_channel.sv
// One arbitration channel: round-robin grant, IDLE->REQ->DRAIN FSM, wait timeout.
module uart_arb_channel
    import uart_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 1023,
    parameter int          DATA_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic                   excl,
    input  logic                   grab_on_grant,
    input  logic [1:0][DATA_W-1:0] grant_data,
    input  logic [DATA_W-1:0]      done_data,
    input  logic                   ctl_ready,
    output logic                   ctl_valid,
    output logic [1:0]             req_ready,
    output logic                   owner,
    output logic [DATA_W-1:0]      data,
    output logic                   timeout
);

    localparam int              CNT_W      = wait_cnt_w(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);
    localparam logic            TIMEOUT_EN = (WAIT_LIMIT != 0);

    ch_state_e          state_q, state_d;
    logic               owner_q, owner_d;
    logic               prio_q, prio_d;
    logic               valid_q, valid_d;
    logic [1:0]         ready_q, ready_d;
    logic [1:0]         pulsed_q, pulsed_d;
    logic               timed_out_q, timed_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [1:0] elig;
    logic       win;
    logic       grant;
    logic       complete;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        valid_d     = valid_q;
        ready_d     = 2'b00;
        pulsed_d    = ready_q;
        timed_out_d = timed_out_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        grant       = 1'b0;
        complete    = 1'b0;
        timeout     = 1'b0;

        // A requester that just saw its ready pulse is not yet re-requesting.
        elig = req_valid & ~pulsed_q & {~excl, 1'b1};
        if (elig == 2'b11) win = prio_q;
        else               win = elig[CORE];

        case (state_q)
            CH_IDLE: begin
                if (|elig) begin
                    grant       = 1'b1;
                    owner_d     = win;
                    prio_d      = ~win;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                    state_d     = CH_REQ;
                end
            end
            CH_REQ: begin
                if (ctl_ready) begin
                    complete         = 1'b1;
                    ready_d[owner_q] = 1'b1;
                    valid_d          = 1'b0;
                    state_d          = CH_DRAIN;
                end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                    timeout     = 1'b1;
                    timed_out_d = 1'b1;
                    valid_d     = 1'b0;
                    state_d     = CH_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CH_DRAIN: begin
                // Late controller ready after a timeout: one extra DRAIN cycle carries the pulse.
                if (timed_out_q && ctl_ready) begin
                    complete         = 1'b1;
                    ready_d[owner_q] = 1'b1;
                    timed_out_d      = 1'b0;
                end else begin
                    state_d = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase

        if (grant && grab_on_grant)     data_d = grant_data[win];
        if (complete && !grab_on_grant) data_d = done_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CH_IDLE;
            owner_q     <= LOADER;
            prio_q      <= LOADER;
            valid_q     <= 1'b0;
            ready_q     <= 2'b00;
            pulsed_q    <= 2'b00;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            pulsed_q    <= pulsed_d;
            timed_out_q <= timed_out_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
        end
    end

    assign ctl_valid = valid_q;
    assign req_ready = ready_q;
    assign owner     = owner_q;
    assign data      = data_q;

endmodule

// File: rtl/uart_arbiter.sv
// Shares one UART controller between loader and core; independent tx and rx channels.
module uart_arbiter
    import uart_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_tx_valid,
    input  logic [15:0] req_tx_data,
    output logic [1:0]  req_tx_ready,
    input  logic [1:0]  req_rx_valid,
    output logic [7:0]  req_rx_data,
    output logic [1:0]  req_rx_ready,
    output logic [7:0]  ctl_in_data,
    output logic        ctl_in_valid,
    input  logic        ctl_in_ready,
    output logic        ctl_out_valid,
    input  logic [7:0]  ctl_out_data,
    input  logic        ctl_out_ready,
    input  logic        exclusive,
    output logic        tx_owner,
    output logic        rx_owner,
    output logic [TIMEOUT_CNT_W-1:0] timeout_count
);

    logic tx_timeout, rx_timeout;
    logic [TIMEOUT_CNT_W-1:0] timeout_count_q, timeout_count_d;
    logic [TIMEOUT_CNT_W:0]   timeout_sum;

    // tx latches the owner's byte at grant; rx latches the controller byte at completion.
    uart_arb_channel #(.WAIT_LIMIT(WAIT_LIMIT), .DATA_W(8)) u_tx (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_tx_valid),
        .excl          (exclusive),
        .grab_on_grant (1'b1),
        .grant_data    (req_tx_data),
        .done_data     (8'h00),
        .ctl_ready     (ctl_in_ready),
        .ctl_valid     (ctl_in_valid),
        .req_ready     (req_tx_ready),
        .owner         (tx_owner),
        .data          (ctl_in_data),
        .timeout       (tx_timeout)
    );

    uart_arb_channel #(.WAIT_LIMIT(WAIT_LIMIT), .DATA_W(8)) u_rx (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_rx_valid),
        .excl          (exclusive),
        .grab_on_grant (1'b0),
        .grant_data    (16'h0000),
        .done_data     (ctl_out_data),
        .ctl_ready     (ctl_out_ready),
        .ctl_valid     (ctl_out_valid),
        .req_ready     (req_rx_ready),
        .owner         (rx_owner),
        .data          (req_rx_data),
        .timeout       (rx_timeout)
    );

    always_comb begin
        timeout_sum     = {1'b0, timeout_count_q} + {{TIMEOUT_CNT_W{1'b0}}, tx_timeout}
                        + {{TIMEOUT_CNT_W{1'b0}}, rx_timeout};
        timeout_count_d = timeout_sum[TIMEOUT_CNT_W] ? {TIMEOUT_CNT_W{1'b1}}
                                                     : timeout_sum[TIMEOUT_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) timeout_count_q <= '0;
        else       timeout_count_q <= timeout_count_d;
    end

    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter: single tx, rx round-robin, timeout, exclusive, reset abort.
module tb_uart_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_tx_valid;
    logic [15:0] req_tx_data;
    logic [1:0]  req_tx_ready;
    logic [1:0]  req_rx_valid;
    logic [7:0]  req_rx_data;
    logic [1:0]  req_rx_ready;
    logic [7:0]  ctl_in_data;
    logic        ctl_in_valid;
    logic        ctl_in_ready;
    logic        ctl_out_valid;
    logic [7:0]  ctl_out_data;
    logic        ctl_out_ready;
    logic        exclusive;
    logic        tx_owner;
    logic        rx_owner;
    logic [7:0]  timeout_count;

    int n_cmp = 0;
    int n_bad = 0;

    uart_arbiter #(.WAIT_LIMIT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_tx_valid  (req_tx_valid),
        .req_tx_data   (req_tx_data),
        .req_tx_ready  (req_tx_ready),
        .req_rx_valid  (req_rx_valid),
        .req_rx_data   (req_rx_data),
        .req_rx_ready  (req_rx_ready),
        .ctl_in_data   (ctl_in_data),
        .ctl_in_valid  (ctl_in_valid),
        .ctl_in_ready  (ctl_in_ready),
        .ctl_out_valid (ctl_out_valid),
        .ctl_out_data  (ctl_out_data),
        .ctl_out_ready (ctl_out_ready),
        .exclusive     (exclusive),
        .tx_owner      (tx_owner),
        .rx_owner      (rx_owner),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Outputs are all registered, so sampling 1 time unit after the edge is stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_pulse;
        int         n;
        int         w;
        logic       flag;

        reset = 1'b1; req_tx_valid = '0; req_tx_data = '0; req_rx_valid = '0;
        ctl_in_ready = 1'b0; ctl_out_data = '0; ctl_out_ready = 1'b0; exclusive = 1'b0;
        repeat (3) tick();
        chk("rst_in_valid",  ctl_in_valid,  0);
        chk("rst_out_valid", ctl_out_valid, 0);
        chk("rst_tx_ready",  req_tx_ready,  0);
        chk("rst_rx_ready",  req_rx_ready,  0);
        chk("rst_tocount",   timeout_count, 0);
        chk("rst_in_data",   ctl_in_data,   0);
        reset = 1'b0;
        tick();

        // single loader tx, controller ready one cycle after valid
        req_tx_data = 16'h9941; req_tx_valid = 2'b01;
        tick();
        chk("tx_valid_t1",  ctl_in_valid, 1);
        chk("tx_data_t1",   ctl_in_data,  8'h41);
        chk("tx_owner_t1",  tx_owner,     0);
        chk("tx_ready_t1",  req_tx_ready, 0);
        tick();
        chk("tx_ready_t2",  req_tx_ready, 0);
        ctl_in_ready = 1'b1;
        tick();
        ctl_in_ready = 1'b0;
        chk("tx_ready_t3",  req_tx_ready, 2'b01);
        chk("tx_valid_t3",  ctl_in_valid, 0);
        req_tx_valid = 2'b00;
        tick();
        chk("tx_ready_once", req_tx_ready, 0);

        // rx contention: both requesters hold valid, grants must alternate
        req_rx_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (!ctl_out_valid && w < 10) begin tick(); w++; end
            chk("rr_grant_seen", ctl_out_valid, 1);
            chk("rr_owner", rx_owner, 32'(i & 1));
            ctl_out_data = 8'h10 + 8'(i); ctl_out_ready = 1'b1;
            tick();
            ctl_out_ready = 1'b0;
            exp_pulse = (i & 1) ? 2'b10 : 2'b01;
            chk("rr_pulse", req_rx_ready, exp_pulse);
            chk("rr_byte",  req_rx_data,  8'h10 + 8'(i));
            req_rx_valid = 2'b11 & ~exp_pulse;
            tick();
            req_rx_valid = (i < 3) ? 2'b11 : 2'b00;
        end
        repeat (2) tick();

        // timeout: controller never answers during REQ
        req_rx_valid = 2'b01;
        tick();
        n = 0; flag = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!ctl_out_valid) break;
            n++;
            if (req_rx_ready != 2'b00) flag = 1'b1;
            tick();
        end
        chk("to_valid_cycles", n, 8);
        chk("to_no_pulse",     flag, 0);
        chk("to_count",        timeout_count, 1);
        chk("to_drain_ready",  req_rx_ready, 0);
        ctl_out_data = 8'h5A; ctl_out_ready = 1'b1;
        tick();
        ctl_out_ready = 1'b0;
        chk("late_pulse", req_rx_ready, 2'b01);
        chk("late_byte",  req_rx_data,  8'h5A);
        req_rx_valid = 2'b00;
        tick();
        chk("late_pulse_once", req_rx_ready, 0);

        // ready on the last allowed cycle counts as completion
        tick();
        req_rx_valid = 2'b01;
        tick();
        repeat (7) tick();
        chk("edge_valid", ctl_out_valid, 1);
        ctl_out_data = 8'h6B; ctl_out_ready = 1'b1;
        tick();
        ctl_out_ready = 1'b0;
        chk("edge_pulse",      req_rx_ready,  2'b01);
        chk("edge_byte",       req_rx_data,   8'h6B);
        chk("edge_no_timeout", timeout_count, 1);
        req_rx_valid = 2'b00;
        tick();

        // exclusive blocks the core, dropping it lets the core in
        exclusive = 1'b1; req_tx_data = 16'h7700; req_tx_valid = 2'b10; flag = 1'b0;
        repeat (20) begin
            tick();
            if (ctl_in_valid) flag = 1'b1;
        end
        chk("excl_no_core", flag, 0);
        exclusive = 1'b0; w = 0;
        while (!ctl_in_valid && w < 5) begin tick(); w++; end
        chk("excl_drop_within2", 32'(w <= 2 && ctl_in_valid), 1);
        chk("excl_core_owner",   tx_owner,    1);
        chk("excl_core_data",    ctl_in_data, 8'h77);
        exclusive = 1'b1;
        tick();
        ctl_in_ready = 1'b1;
        tick();
        ctl_in_ready = 1'b0;
        chk("excl_mid_pulse", req_tx_ready, 2'b10);
        req_tx_valid = 2'b00; exclusive = 1'b0;
        tick();

        // reset while a tx grant sits in REQ
        req_tx_data = 16'h0033; req_tx_valid = 2'b01;
        tick();
        chk("rstreq_pre_valid", ctl_in_valid, 1);
        reset = 1'b1; ctl_in_ready = 1'b1;
        tick();
        chk("rstreq_in_valid", ctl_in_valid,  0);
        chk("rstreq_tx_ready", req_tx_ready,  0);
        chk("rstreq_in_data",  ctl_in_data,   0);
        chk("rstreq_rx_data",  req_rx_data,   0);
        chk("rstreq_tocount",  timeout_count, 0);
        chk("rstreq_owners",   {tx_owner, rx_owner}, 0);
        reset = 1'b0; ctl_in_ready = 1'b0; req_tx_valid = 2'b00;
        tick();
        chk("rstreq_no_pulse", req_tx_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter: WAIT_LIMIT, 1023, max cycles a grant waits for controller ready before abandoning; 0 disables the timeout.
REQ-002 clk  in  1  system clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_tx_valid  in  2  per-requester transmit request (bit0 = loader, bit1 = core).
REQ-005 req_tx_data  in  16  transmit bytes: [7:0] loader, [15:8] core.
REQ-006 req_tx_ready  out  2  one-cycle per-requester transmit-accepted pulse.
REQ-007 req_rx_valid  in  2  per-requester receive request.
REQ-008 req_rx_data  out  8  received byte, valid only while the owner's req_rx_ready bit is high.
REQ-009 req_rx_ready  out  2  one-cycle per-requester receive-complete pulse.
REQ-010 ctl_in_data / ctl_in_valid  out  8 / 1  to controller transmit-push port.
REQ-011 ctl_in_ready  in  1  controller one-cycle push-accepted pulse.
REQ-012 ctl_out_valid  out  1  to controller receive-pop port.
REQ-013 ctl_out_data / ctl_out_ready  in  8 / 1  controller pop data and one-cycle pop-accepted pulse.
REQ-014 exclusive  in  1  when high, only the loader may be granted on either channel.
REQ-015 tx_owner / rx_owner  out  1 / 1  index of the current or last grant holder.
REQ-016 timeout_count  out  8  saturating count of abandoned grants, both channels.

Function
REQ-017 Two independent channels (tx, rx) SHALL each run the FSM IDLE -> REQ -> DRAIN -> IDLE.
REQ-018 IDLE: if any eligible request is valid, grant one, register the owner, and enter REQ next cycle; otherwise remain in IDLE.
REQ-019 Arbitration SHALL be round-robin: on a tie, the requester not served last wins; after reset the loader wins.
REQ-020 Eligibility: valid high; not the requester pulsed ready in the previous cycle; core excluded while exclusive is high.
REQ-021 REQ: ctl_*_valid SHALL be high, driven from registers; tx data SHALL be latched from the owner at grant time and held stable.
REQ-022 REQ with controller ready high: go to DRAIN; owner's req_*_ready SHALL pulse for exactly the DRAIN cycle; rx data SHALL be registered into req_rx_data.
REQ-023 REQ wait counter SHALL increment each cycle; at WAIT_LIMIT with no ready, go to DRAIN without a requester pulse and increment timeout_count, saturating at 255.
REQ-024 Ready and timeout in the same cycle SHALL be treated as completion, not timeout.
REQ-025 DRAIN: ctl_*_valid SHALL be low; a controller ready arriving in DRAIN after a timeout SHALL still complete the transfer, with the owner's pulse in the following cycle, after which the channel returns to IDLE.
REQ-026 Latency: request at IDLE cycle t -> ctl valid at t+1 -> earliest requester ready at t+3.
REQ-027 Requesters SHALL deassert valid the cycle after their ready pulse; a valid held longer SHALL be treated as a new request.
REQ-028 exclusive rising while the core holds a grant SHALL NOT abort that transaction; it only affects subsequent grants.
REQ-029 Channels SHALL be fully concurrent; one requester may own tx while the other owns rx.

Reset
REQ-030 On reset, both channels SHALL go to IDLE; all ready, valid, and data outputs 0; owners 0 and last-served state cleared; wait counters 0; timeout_count 0.
REQ-031 Reset mid-transaction SHALL drop ctl_*_valid in the next cycle; no requester pulse SHALL be issued for the aborted transfer.

Structure
REQ-032 Package uart_arbiter_pkg SHALL hold the channel-state enum, requester index constants (LOADER=0, CORE=1), and the timeout counter width derived from WAIT_LIMIT.
REQ-033 One sub-module, uart_arb_channel (FSM, round-robin pointer, wait counter), SHALL be instantiated twice: data width 8 for tx, 8 for rx.

Verification
REQ-034 Single tx: loader valid, data 0x41; controller ready 1 cycle after valid -> ctl_in_data 0x41, req_tx_ready[0] pulses once, at t+3.
REQ-035 Contention: both valid on rx for 4 back-to-back transactions with bytes 0x10..0x13 -> grants alternate loader, core, loader, core; each byte goes to the matching owner.
REQ-036 Timeout: WAIT_LIMIT=8, rx request, controller buffer empty -> ctl_out_valid high for 8 cycles then low; timeout_count=1; no req_rx_ready pulse; a late ready in DRAIN -> pulse delivered.
REQ-037 exclusive=1, core valid on tx for 20 cycles -> no core grant; exclusive drop -> core granted within 2 cycles.
REQ-038 Reset asserted in REQ -> ctl_in_valid 0 next cycle, no req_tx_ready pulse, all outputs at reset values.
